// File: rtl/mii_rx_framer_pkg.sv
// rtl/mii_rx_framer_pkg.sv - shared types, constants and CRC helpers for the MII receive framer
//
// Contents: framer state encoding, preamble/SFD nibbles, CRC32 residue and
// polynomial, default frame length limits, byte-wise reflected CRC32 update
// and a 32-bit bit-reverse helper.
package mii_rx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        FLUSH,
        DISCARD
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;

    // Residue of a good frame (data + FCS) with init 0xFFFFFFFF and no final
    // XOR, expressed MSB-first; the shift register itself runs reflected.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

    localparam int MIN_LEN_DEFAULT = 64;
    localparam int MAX_LEN_DEFAULT = 1518;

    // One byte through the reflected (LSB-first) CRC32 register.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mii_rx_framer_if.sv
// rtl/mii_rx_framer_if.sv - byte write port between the framer and the downstream FIFO
//
// Signals: rx_data (byte), rx_sop/rx_eop/rx_err (frame flags), rx_wren (write
// strobe qualifying data and flags), rx_full (FIFO cannot accept a byte).
// master = framer side, slave = FIFO side.
interface mii_rx_framer_if;
    logic [7:0] rx_data;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_err;
    logic       rx_wren;
    logic       rx_full;

    modport master (
        output rx_data, rx_sop, rx_eop, rx_err, rx_wren,
        input  rx_full
    );

    modport slave (
        input  rx_data, rx_sop, rx_eop, rx_err, rx_wren,
        output rx_full
    );
endinterface

// File: rtl/mii_rx_framer_crc32.sv
// rtl/mii_rx_framer_crc32.sv - byte-wide reflected CRC32 accumulator
//
// Ports: clk, rst (sync active-high), init (load 0xFFFFFFFF), en (absorb data),
// data[7:0], crc_nxt[31:0] (register value after this cycle's update, reflected).
module mii_rx_framer_crc32
    import mii_rx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_nxt
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = 32'hFFFFFFFF;
        end else if (en) begin
            crc_d = crc32_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 32'h00000000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_nxt = crc_d;

endmodule

// File: rtl/mii_rx_framer.sv
// rtl/mii_rx_framer.sv - MII nibble receiver: frame delineation, byte assembly, CRC/length checks
//
// Ports: eth_rxclk, rst (sync active-high), eth_rxdv, eth_rxer, eth_rxd[3:0],
// wr (mii_rx_framer_if.master byte write port), frames_ok[15:0], frames_bad[15:0].
// Parameters: MIN_LEN, MAX_LEN (frame bytes including FCS).
// Build option: MII_RX_STRIP_FCS_EN drops the 4 FCS bytes from the written stream.
module mii_rx_framer
    import mii_rx_framer_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEFAULT,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic                   eth_rxclk,
    input  logic                   rst,
    input  logic                   eth_rxdv,
    input  logic                   eth_rxer,
    input  logic [3:0]             eth_rxd,
    mii_rx_framer_if.master        wr,
    output logic [15:0]            frames_ok,
    output logic [15:0]            frames_bad
);

    // Bytes held back before a byte may be written. With no stripping one
    // byte is pending so the last byte can carry eop; stripping holds four
    // more so the FCS never reaches the write port.
`ifdef MII_RX_STRIP_FCS_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 0;
`endif

    state_t             state_q, state_d;
    logic               ph_q, ph_d;
    logic [3:0]         lo_q, lo_d;
    logic [7:0]         nb_q, nb_d;
    logic               nb_vld_q, nb_vld_d;
    logic [DLY:0][7:0]  pipe_q, pipe_d;
    logic [10:0]        cnt_q, cnt_d;
    logic               rxer_q, rxer_d;
    logic               ovf_q, ovf_d;
    logic               wrote_q, wrote_d;
    logic [7:0]         data_q, data_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               err_q, err_d;
    logic               wren_q, wren_d;
    logic [15:0]        ok_q, ok_d;
    logic [15:0]        bad_q, bad_d;

    logic               crc_init;
    logic [31:0]        crc_nxt;
    logic [7:0]         byte_now;
    int                 cnt_i;
    int                 pend_idx;
    logic               pend_ok;
    logic               frame_err;

    // The CRC sees each byte one cycle after it completes; at the rxdv fall
    // crc_nxt already includes that final byte.
    mii_rx_framer_crc32 u_crc (
        .clk     (eth_rxclk),
        .rst     (rst),
        .init    (crc_init),
        .en      (nb_vld_q),
        .data    (nb_q),
        .crc_nxt (crc_nxt)
    );

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        lo_d     = lo_q;
        nb_d     = nb_q;
        nb_vld_d = 1'b0;
        pipe_d   = pipe_q;
        cnt_d    = cnt_q;
        rxer_d   = rxer_q;
        ovf_d    = ovf_q;
        wrote_d  = wrote_q;
        data_d   = 8'h00;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        err_d    = 1'b0;
        wren_d   = 1'b0;
        ok_d     = ok_q;
        bad_d    = bad_q;
        crc_init = 1'b0;

        byte_now = {eth_rxd, lo_q};
        cnt_i    = int'(cnt_q);
        // 1-based index of the byte sitting at the end of the delay line.
        pend_idx = cnt_i - DLY;
        pend_ok  = (pend_idx >= 1) && (pend_idx <= MAX_LEN) && !ovf_q;
        frame_err = rxer_q || (bitrev32(crc_nxt) != CRC32_RESIDUE) ||
                    (cnt_i < MIN_LEN) || (cnt_i > MAX_LEN) || ph_q || ovf_q;

        case (state_q)
            IDLE: begin
                if (eth_rxdv) begin
                    state_d = (eth_rxd == PREAMBLE_NIBBLE) ? PREAMBLE : DISCARD;
                end
            end

            PREAMBLE: begin
                if (eth_rxdv && eth_rxd == PREAMBLE_NIBBLE) begin
                    state_d = PREAMBLE;
                end else if (eth_rxdv && eth_rxd == SFD_NIBBLE) begin
                    state_d  = DATA;
                    ph_d     = 1'b0;
                    cnt_d    = 11'd0;
                    crc_init = 1'b1;
                    rxer_d   = 1'b0;
                    ovf_d    = 1'b0;
                    wrote_d  = 1'b0;
                end else begin
                    state_d = DISCARD;
                end
            end

            DATA: begin
                if (!eth_rxdv) begin
                    state_d = FLUSH;
                    if (cnt_q != 11'd0) begin
                        wren_d = 1'b1;
                        eop_d  = 1'b1;
                        sop_d  = !wrote_q;
                        err_d  = frame_err;
                        if (pend_ok) begin
                            data_d = pipe_q[DLY];
                        end else begin
                            // Nothing legitimate left to deliver: terminate
                            // the frame with an empty errored eop.
                            data_d = 8'h00;
                            err_d  = 1'b1;
                        end
                        if (err_d) begin
                            if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
                        end else begin
                            if (ok_q != 16'hFFFF) ok_d = ok_q + 16'd1;
                        end
                    end
                end else begin
                    if (eth_rxer) rxer_d = 1'b1;
                    if (!ph_q) begin
                        lo_d = eth_rxd;
                        ph_d = 1'b1;
                    end else begin
                        ph_d     = 1'b0;
                        nb_d     = byte_now;
                        nb_vld_d = 1'b1;
                        if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
                        if (pend_ok) begin
                            if (wr.rx_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                wren_d  = 1'b1;
                                data_d  = pipe_q[DLY];
                                sop_d   = !wrote_q;
                                wrote_d = 1'b1;
                            end
                        end
                        for (int k = DLY; k > 0; k--) begin
                            pipe_d[k] = pipe_q[k-1];
                        end
                        pipe_d[0] = byte_now;
                    end
                end
            end

            FLUSH: begin
                state_d = IDLE;
            end

            DISCARD: begin
                if (!eth_rxdv) state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge eth_rxclk) begin
        if (rst) begin
            state_q  <= IDLE;
            ph_q     <= 1'b0;
            lo_q     <= 4'h0;
            nb_q     <= 8'h00;
            nb_vld_q <= 1'b0;
            pipe_q   <= '0;
            cnt_q    <= 11'd0;
            rxer_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wrote_q  <= 1'b0;
            data_q   <= 8'h00;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
            wren_q   <= 1'b0;
            ok_q     <= 16'h0000;
            bad_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            lo_q     <= lo_d;
            nb_q     <= nb_d;
            nb_vld_q <= nb_vld_d;
            pipe_q   <= pipe_d;
            cnt_q    <= cnt_d;
            rxer_q   <= rxer_d;
            ovf_q    <= ovf_d;
            wrote_q  <= wrote_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
            wren_q   <= wren_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
        end
    end

    assign wr.rx_data  = data_q;
    assign wr.rx_sop   = sop_q;
    assign wr.rx_eop   = eop_q;
    assign wr.rx_err   = err_q;
    assign wr.rx_wren  = wren_q;
    assign frames_ok   = ok_q;
    assign frames_bad  = bad_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// tb/tb_mii_rx_framer.sv - directed self-checking bench for mii_rx_framer
module tb_mii_rx_framer;

`ifdef MII_RX_STRIP_FCS_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 0;
`endif

    logic        clk;
    logic        rst;
    logic        eth_rxdv;
    logic        eth_rxer;
    logic [3:0]  eth_rxd;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    mii_rx_framer_if wr_if ();

    mii_rx_framer dut (
        .eth_rxclk  (clk),
        .rst        (rst),
        .eth_rxdv   (eth_rxdv),
        .eth_rxer   (eth_rxer),
        .eth_rxd    (eth_rxd),
        .wr         (wr_if),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Captured writes: {err, eop, sop, data}
    logic [10:0] wq[$];

    always @(negedge clk) begin
        if (wr_if.rx_wren === 1'b1) begin
            wq.push_back({wr_if.rx_err, wr_if.rx_eop, wr_if.rx_sop, wr_if.rx_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Standard Ethernet FCS: reflected CRC32, init all-ones, complemented,
    // sent least significant byte first.
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input int npay, input int flip_idx, output logic [7:0] q[$]);
        logic [31:0] f;
        q = {};
        for (int j = 0; j < npay; j++) q.push_back(8'(j));
        f = fcs_of(q);
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
        q.push_back(f[23:16]);
        q.push_back(f[31:24]);
        if (flip_idx >= 0) q[flip_idx] = q[flip_idx] ^ 8'h04;
    endtask

    task automatic nib(input logic [3:0] d, input logic dv, input logic er,
                       input logic full, input logic r);
        @(negedge clk);
        eth_rxd       = d;
        eth_rxdv      = dv;
        eth_rxer      = er;
        wr_if.rx_full = full;
        rst           = r;
    endtask

    // Byte positions are 1-based data bytes after the SFD; 0 disables.
    // rxer and rst land on the low nibble, rx_full on the high nibble.
    task automatic send_frame(input logic [7:0] d[$], input int full_byte,
                              input int rxer_byte, input int rst_byte);
        for (int i = 0; i < 7; i++) begin
            nib(4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
            nib(4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        nib(4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        nib(4'hD, 1'b1, 1'b0, 1'b0, 1'b0);
        foreach (d[j]) begin
            nib(d[j][3:0], 1'b1, (j + 1) == rxer_byte, 1'b0, (j + 1) == rst_byte);
            nib(d[j][7:4], 1'b1, 1'b0, (j + 1) == full_byte, 1'b0);
        end
        nib(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) nib(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] exp[$], input logic exp_err);
        int nm, nsop, neop, nerr;
        nm = 0; nsop = 0; neop = 0; nerr = 0;
        chk({tag, " writes"}, wq.size(), exp.size());
        foreach (wq[i]) begin
            if (i < exp.size() && wq[i][7:0] !== exp[i]) nm++;
            nsop += int'(wq[i][8]);
            neop += int'(wq[i][9]);
            if (i != wq.size() - 1) nerr += int'(wq[i][10]);
        end
        chk({tag, " data mismatches"}, nm, 0);
        chk({tag, " sop count"}, nsop, 1);
        chk({tag, " eop count"}, neop, 1);
        chk({tag, " non-eop err"}, nerr, 0);
        if (wq.size() > 0) begin
            chk({tag, " first sop"}, 32'(wq[0][8]), 1);
            chk({tag, " last eop"}, 32'(wq[wq.size()-1][9]), 1);
            chk({tag, " eop err"}, 32'(wq[wq.size()-1][10]), 32'(exp_err));
        end
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] ex[$];
        int         nw, neop;

        rst = 1'b1; eth_rxdv = 1'b0; eth_rxer = 1'b0; eth_rxd = 4'h0; wr_if.rx_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset wren", 32'(wr_if.rx_wren), 0);
        chk("reset sop", 32'(wr_if.rx_sop), 0);
        chk("reset eop", 32'(wr_if.rx_eop), 0);
        chk("reset err", 32'(wr_if.rx_err), 0);
        chk("reset data", 32'(wr_if.rx_data), 0);
        chk("reset frames_ok", 32'(frames_ok), 0);
        chk("reset frames_bad", 32'(frames_bad), 0);
        nib(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) nib(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Good 64-byte frame
        build_frame(60, -1, fr);
        wq.delete();
        send_frame(fr, 0, 0, 0);
        ex = fr[0:63-DLY];
        check_writes("good64", ex, 1'b0);
        chk("good64 frames_ok", 32'(frames_ok), 1);
        chk("good64 frames_bad", 32'(frames_bad), 0);

        // Same frame with one payload bit flipped
        build_frame(60, 10, fr);
        wq.delete();
        send_frame(fr, 0, 0, 0);
        ex = fr[0:63-DLY];
        check_writes("crcbad", ex, 1'b1);
        chk("crcbad frames_bad", 32'(frames_bad), 1);

        // Overflow: rx_full while byte 10's write is being launched
        build_frame(60, -1, fr);
        wq.delete();
        send_frame(fr, 11, 0, 0);
        ex = fr[0:8-DLY];
        ex.push_back(8'h00);
        check_writes("ovf", ex, 1'b1);
        chk("ovf frames_bad", 32'(frames_bad), 2);

        // Receive error on byte 20
        wq.delete();
        send_frame(fr, 0, 20, 0);
        ex = fr[0:63-DLY];
        check_writes("rxer", ex, 1'b1);
        chk("rxer frames_bad", 32'(frames_bad), 3);

        // 40-byte runt with valid CRC
        build_frame(36, -1, fr);
        wq.delete();
        send_frame(fr, 0, 0, 0);
        ex = fr[0:39-DLY];
        check_writes("runt", ex, 1'b1);
        chk("runt frames_bad", 32'(frames_bad), 4);
        chk("runt frames_ok", 32'(frames_ok), 1);

        // SFD directly followed by rxdv low: nothing written, nothing counted
        fr = {};
        wq.delete();
        send_frame(fr, 0, 0, 0);
        chk("empty writes", wq.size(), 0);
        chk("empty frames_ok", 32'(frames_ok), 1);
        chk("empty frames_bad", 32'(frames_bad), 4);

        // Reset pulsed at byte 30 while the frame keeps streaming
        build_frame(60, -1, fr);
        wq.delete();
        send_frame(fr, 0, 0, 30);
        nw = wq.size();
        neop = 0;
        foreach (wq[i]) neop += int'(wq[i][9]);
        chk("rst writes", nw, 28 - DLY);
        chk("rst eop count", neop, 0);
        chk("rst frames_ok", 32'(frames_ok), 0);
        chk("rst frames_bad", 32'(frames_bad), 0);

        // Next frame after the reset is received normally
        wq.delete();
        send_frame(fr, 0, 0, 0);
        ex = fr[0:63-DLY];
        check_writes("post-rst", ex, 1'b0);
        chk("post-rst frames_ok", 32'(frames_ok), 1);
        chk("post-rst frames_bad", 32'(frames_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
